// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, and generates the ALU operation select.
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

  state_t state_q, state_d, cur_state;
  aluop_t alu_op;
  logic   pc_update, branch, legal_op;

  assign legal_op = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
                    (op == 7'b0010011) || (op == 7'b1101111) || (op == 7'b1100011);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECUTER;
          7'b0010011:             state_d = S_EXECUTEI;
          7'b1101111:             state_d = S_JAL;
          7'b1100011:             state_d = S_BEQ;
          default:                state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so the register updates race-free against other clocked logic.
    if (!rst) state_q <= state_t'(RESET_STATE);
    else      state_q <= state_d;
  end

  // While in reset, outputs decode as the reset state even before the clock edge.
  assign cur_state = rst ? state_q : state_t'(RESET_STATE);

  always_comb begin
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    case (cur_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
    // Write enables are suppressed for the whole time reset is held low.
    if (!rst) begin
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
    end
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      ALUOP_SUB:   ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default:     ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  assign PCWrite    = pc_update || (branch && Zero);
  assign illegal_op = rst && (cur_state == S_DECODE) && !legal_op;
  assign state_dbg  = rst ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; outputs are sampled on the
// falling clock edge, inputs change on the falling edge after sampling.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic walk_state(input string tag, input logic [3:0] exp);
    cyc();
    check(tag, 32'(state_dbg), 32'(exp));
  endtask

  logic [2:0] f3_tab [3] = '{3'b010, 3'b110, 3'b111};
  logic [2:0] alu_tab[3] = '{3'b101, 3'b011, 3'b010};

  initial begin
    rst = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    Zero = 1'b0; mem_ready = 1'b1;

    // Reset held for two cycles
    cyc();
    check("rst_state", 32'(state_dbg), 0);
    check("rst_pcwrite", 32'(PCWrite), 0);
    check("rst_irwrite", 32'(IRWrite), 0);
    check("rst_memwrite", 32'(MemWrite), 0);
    check("rst_regwrite", 32'(RegWrite), 0);
    check("rst_alusrcb", 32'(ALUSrcB), 2);
    check("rst_resultsrc", 32'(ResultSrc), 2);
    cyc();
    check("rst_state2", 32'(state_dbg), 0);
    check("rst_irwrite2", 32'(IRWrite), 0);
    rst = 1'b1;
    #1;
    check("fetch_state", 32'(state_dbg), 0);
    check("fetch_irwrite", 32'(IRWrite), 1);
    check("fetch_pcwrite", 32'(PCWrite), 1);
    check("fetch_alusrcb", 32'(ALUSrcB), 2);
    check("fetch_resultsrc", 32'(ResultSrc), 2);
    check("fetch_adrsrc", 32'(AdrSrc), 0);

    // R-type sub: 0,1,6,7,0
    walk_state("rsub_decode", 1);
    check("rsub_dec_srca", 32'(ALUSrcA), 1);
    check("rsub_dec_srcb", 32'(ALUSrcB), 1);
    check("rsub_dec_alu", 32'(ALUControl), 0);
    check("rsub_dec_illegal", 32'(illegal_op), 0);
    walk_state("rsub_exec", 6);
    check("rsub_alu", 32'(ALUControl), 3'b001);
    check("rsub_exec_srca", 32'(ALUSrcA), 2);
    check("rsub_exec_srcb", 32'(ALUSrcB), 0);
    check("rsub_exec_regwrite", 32'(RegWrite), 0);
    walk_state("rsub_wb", 7);
    check("rsub_wb_regwrite", 32'(RegWrite), 1);
    check("rsub_wb_resultsrc", 32'(ResultSrc), 0);
    walk_state("rsub_done", 0);
    check("rsub_done_regwrite", 32'(RegWrite), 0);

    // addi with funct7b5=1 must not become sub
    op = 7'b0010011;
    walk_state("addi_decode", 1);
    walk_state("addi_exec", 8);
    check("addi_alu", 32'(ALUControl), 3'b000);
    check("addi_srcb", 32'(ALUSrcB), 1);
    walk_state("addi_wb", 7);
    walk_state("addi_done", 0);

    // lw with three stall cycles in MEMREAD
    op = 7'b0000011;
    walk_state("lw_decode", 1);
    walk_state("lw_memadr", 2);
    check("lw_memadr_srca", 32'(ALUSrcA), 2);
    check("lw_memadr_srcb", 32'(ALUSrcB), 1);
    mem_ready = 1'b0;
    walk_state("lw_memread1", 3);
    check("lw_adrsrc", 32'(AdrSrc), 1);
    walk_state("lw_memread2", 3);
    walk_state("lw_memread3", 3);
    walk_state("lw_memread4", 3);
    mem_ready = 1'b1;
    walk_state("lw_memwb", 4);
    check("lw_memwb_resultsrc", 32'(ResultSrc), 1);
    check("lw_memwb_regwrite", 32'(RegWrite), 1);
    walk_state("lw_done", 0);

    // beq taken then not taken
    op = 7'b1100011; Zero = 1'b1;
    walk_state("beq1_decode", 1);
    walk_state("beq1_exec", 10);
    check("beq1_pcwrite", 32'(PCWrite), 1);
    check("beq1_alu", 32'(ALUControl), 3'b001);
    check("beq1_immsrc", 32'(ImmSrc), 2);
    walk_state("beq1_done", 0);
    Zero = 1'b0;
    walk_state("beq0_decode", 1);
    walk_state("beq0_exec", 10);
    check("beq0_pcwrite", 32'(PCWrite), 0);
    walk_state("beq0_done", 0);

    // Illegal opcode pulses illegal_op only in DECODE
    op = 7'b1111111;
    walk_state("ill_decode", 1);
    check("ill_pulse", 32'(illegal_op), 1);
    walk_state("ill_fetch", 0);
    check("ill_cleared", 32'(illegal_op), 0);

    // sw interrupted by reset while waiting in MEMWRITE
    op = 7'b0100011;
    walk_state("sw_decode", 1);
    check("sw_immsrc", 32'(ImmSrc), 1);
    walk_state("sw_memadr", 2);
    walk_state("sw_memwrite", 5);
    check("sw_memwrite_en", 32'(MemWrite), 1);
    check("sw_adrsrc", 32'(AdrSrc), 1);
    mem_ready = 1'b0;
    walk_state("sw_wait", 5);
    check("sw_wait_memwrite", 32'(MemWrite), 1);
    rst = 1'b0;
    #1;
    check("sw_rst_memwrite", 32'(MemWrite), 0);
    check("sw_rst_state", 32'(state_dbg), 0);
    walk_state("sw_rst_next", 0);
    rst = 1'b1; mem_ready = 1'b1; op = 7'b1101111;
    #1;
    check("sw_after_state", 32'(state_dbg), 0);
    check("sw_after_irwrite", 32'(IRWrite), 1);

    // jal
    walk_state("jal_decode", 1);
    walk_state("jal_exec", 9);
    check("jal_pcwrite", 32'(PCWrite), 1);
    check("jal_immsrc", 32'(ImmSrc), 3);
    check("jal_srca", 32'(ALUSrcA), 1);
    check("jal_srcb", 32'(ALUSrcB), 2);
    walk_state("jal_wb", 7);
    check("jal_regwrite", 32'(RegWrite), 1);
    walk_state("jal_done", 0);

    // slt / or / and
    op = 7'b0110011; funct7b5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      funct3 = f3_tab[i];
      walk_state($sformatf("rfn%0d_decode", i), 1);
      walk_state($sformatf("rfn%0d_exec", i), 6);
      check($sformatf("rfn%0d_alu", i), 32'(ALUControl), 32'(alu_tab[i]));
      walk_state($sformatf("rfn%0d_wb", i), 7);
      walk_state($sformatf("rfn%0d_done", i), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle RISC-V control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states.
- It is the driving end of the ALU interface: it generates the 3-bit ALU operation select (000 add, 001 sub, 010 and, 011 or, 101 slt) and consumes the ALU Zero flag to resolve branches.
- It also drives datapath mux selects and write enables, and stalls on a memory-ready handshake.

Parameters:
- RESET_STATE, 0, state encoding entered on reset (FETCH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- op  in  7  instruction opcode (instr[6:0]).
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register and OldPC enable.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RegA.
- ALUSrcB  out  2  00 RegB, 01 ImmExt, 10 constant 4.
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type.
- ALUControl  out  3  ALU operation select.
- RegWrite  out  1  register file write enable.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
- state_dbg  out  4  current state encoding.

Behaviour:
- State register:
  - Updates on the rising edge of clk.
  - rst=0 at a clock edge forces the state to FETCH, including mid-instruction (e.g. a pending MEMWRITE is abandoned).
  - While rst=0, PCWrite, IRWrite, MemWrite, RegWrite and illegal_op are forced to 0.
  - All other outputs take their FETCH values while rst=0; state_dbg reads 0.
- Outputs are Moore decodes of state. ALUControl, ImmSrc and illegal_op also depend on the instruction fields. Unlisted controls in each state are 0 / 00.
- PCWrite = PCUpdate OR (Branch AND Zero).
- States: encoding and actions, then next state.
  - FETCH (0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10. IRWrite=mem_ready, PCUpdate=mem_ready. Holds while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE (1): ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target precompute). Next state by op:
    - 0000011 / 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1101111 → JAL.
    - 1100011 → BEQ.
    - otherwise: illegal_op=1 for this cycle, then → FETCH.
  - MEMADR (2): ALUSrcA=10, ALUSrcB=01, ALUOp=add. op[5]=0 → MEMREAD; op[5]=1 → MEMWRITE.
  - MEMREAD (3): AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then → MEMWB.
  - MEMWB (4): ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWRITE (5): AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays asserted while waiting; → FETCH when mem_ready=1.
  - EXECUTER (6): ALUSrcA=10, ALUSrcB=00, ALUOp=funct → ALUWB.
  - EXECUTEI (8): ALUSrcA=10, ALUSrcB=01, ALUOp=funct → ALUWB.
  - ALUWB (7): ResultSrc=00, RegWrite=1 → FETCH.
  - JAL (9): ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCUpdate=1 → ALUWB.
  - BEQ (10): ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1 → FETCH.
  - Unused encodings → FETCH next cycle.
- ALU decode:
  - ALUOp add → 000; ALUOp sub → 001.
  - ALUOp funct, by funct3:
    - 000 → 001 when op[5]=1 and funct7b5=1 (R-type sub); otherwise 000 (addi is never sub).
    - 010 → 101 (slt).
    - 110 → 011 (or).
    - 111 → 010 (and).
    - any other funct3 → 000.
- ImmSrc from op: 0100011 → 01, 1100011 → 10, 1101111 → 11, else 00.
- Cycle counts with mem_ready held at 1:
  - lw 5, sw 4, R-type/I-type 4, jal 4, beq 3.
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Test Plan:
- Reset: rst=0 for 2 cycles, then 1 → state_dbg=0; PCWrite/IRWrite/MemWrite/RegWrite=0 during reset. First FETCH has IRWrite=1, ALUSrcB=10, ResultSrc=10.
- R-type sub: op=0110011, funct3=000, funct7b5=1 → states 0,1,6,7,0; ALUControl=001 in state 6; RegWrite=1 only in state 7. Repeat with op=0010011, funct7b5=1 → ALUControl=000 in state 8.
- lw with stall: op=0000011, mem_ready=0 for 3 cycles in MEMREAD → states 0,1,2,3,3,3,3,4,0; ResultSrc=01 and RegWrite=1 in state 4.
- beq: op=1100011 with Zero=1 → PCWrite=1 in state 10, ALUControl=001. With Zero=0 → PCWrite=0. Both return to FETCH after 3 cycles.
- Illegal and mid-op reset: op=1111111 → illegal_op pulses for exactly 1 cycle in DECODE, then FETCH. sw with rst=0 asserted in MEMWRITE → MemWrite=0 that cycle and state_dbg=0 the next cycle.
- jal / slt / or / and: op=1101111 → PCWrite=1 in state 9, ImmSrc=11, then RegWrite in state 7. R-type funct3=010/110/111 → ALUControl 101/011/010.
